// File: rtl/fetch_if.sv
// Fetch-stage handshake bundle: control inputs from the core, ROM port,
// and the registered instruction stream toward the decoder.
interface fetch_if #(
  parameter int unsigned PC_W = 10
);
  logic            start;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data;
  logic [8:0]      mach_code;
  logic            mode;
  logic            instr_valid;
  logic [PC_W-1:0] instr_pc;
  logic            done;

  // Environment side: drives control and ROM data, observes fetch outputs.
  modport master (
    output start, stall, branch_taken, branch_target, imem_data,
    input  imem_addr, mach_code, mode, instr_valid, instr_pc, done
  );

  // Fetch unit side.
  modport slave (
    input  start, stall, branch_taken, branch_target, imem_data,
    output imem_addr, mach_code, mode, instr_valid, instr_pc, done
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and the reg-reg/reg-imm mode flag,
// reads the combinational ROM and registers the word for the decoder.
// Mode-switch and halt encodings are consumed here and never forwarded.
module fetch_unit #(
  parameter int unsigned PC_W         = 10,
  parameter logic [8:0]  MODE_SW_CODE = 9'h1FF,
  parameter logic [8:0]  HALT_CODE    = 9'h1FE
) (
  input logic     clk,
  input logic     reset,
  fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      code;
  logic            mode_flag;
  logic            valid;
  logic [PC_W-1:0] fetched_pc;
  logic            halted;

  // ROM is addressed straight from the PC register.
  assign bus.imem_addr   = pc;
  assign bus.mach_code   = code;
  assign bus.mode        = mode_flag;
  assign bus.instr_valid = valid;
  assign bus.instr_pc    = fetched_pc;
  assign bus.done        = halted;

  // Fetch FSM: PC update, instruction register and mode/halt handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      code       <= '0;
      mode_flag  <= 1'b0;
      valid      <= 1'b0;
      fetched_pc <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc    <= '0;
          valid <= 1'b0;
          if (bus.start) state <= RUN;
        end

        RUN: begin
          if (bus.branch_taken) begin
            // Redirect wins over stall; the word fetched this cycle is dropped
            // without inspecting it for mode-switch or halt.
            pc         <= bus.branch_target;
            code       <= '0;
            valid      <= 1'b0;
            fetched_pc <= pc;
          end else if (bus.stall) begin
            // Hold everything so the decoder sees the same instruction again.
          end else if (bus.imem_data == HALT_CODE) begin
            code       <= '0;
            valid      <= 1'b0;
            fetched_pc <= pc;
            halted     <= 1'b1;
            state      <= HALT;
          end else begin
            fetched_pc <= pc;
            pc         <= pc + PC_W'(1);
            if (bus.imem_data == MODE_SW_CODE) begin
              mode_flag <= ~mode_flag;
              code      <= '0;
              valid     <= 1'b0;
            end else begin
              code  <= bus.imem_data;
              valid <= 1'b1;
            end
          end
        end

        HALT: begin
          valid <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one PC_W=10 instance for the functional
// scenarios and one PC_W=4 instance for PC wraparound.
module tb_fetch_unit;

  logic clk;
  logic reset;
  logic reset4;
  int   total;
  int   bad;

  logic [8:0] rom  [0:1023];
  logic [8:0] rom4 [0:15];

  fetch_if #(.PC_W(10)) b10 ();
  fetch_if #(.PC_W(4))  b4  ();

  fetch_unit #(.PC_W(10), .MODE_SW_CODE(9'h1FF), .HALT_CODE(9'h1FE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b10)
  );

  fetch_unit #(.PC_W(4), .MODE_SW_CODE(9'h1FF), .HALT_CODE(9'h1FE)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (b4)
  );

  always_comb b10.imem_data = rom[b10.imem_addr];
  always_comb b4.imem_data  = rom4[b4.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
  endtask

  // Reset the main instance, then pulse start; returns with state RUN, pc = 0.
  task automatic reset_and_start();
    reset = 1'b1;
    b10.start = 1'b0;
    b10.stall = 1'b0;
    b10.branch_taken = 1'b0;
    b10.branch_target = '0;
    step();
    reset = 1'b0;
    b10.start = 1'b1;
    step();
    b10.start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    reset4 = 1'b1;
    b10.start = 1'b0; b10.stall = 1'b0; b10.branch_taken = 1'b0; b10.branch_target = '0;
    b4.start  = 1'b0; b4.stall  = 1'b0; b4.branch_taken  = 1'b0; b4.branch_target  = '0;
    clear_rom();
    for (int i = 0; i < 16; i++) rom4[i] = 9'h100 + 9'(i);

    // ---- reset state
    step();
    check("rst_mach", b10.mach_code, 9'h000);
    check("rst_mode", b10.mode, 1'b0);
    check("rst_valid", b10.instr_valid, 1'b0);
    check("rst_ipc", b10.instr_pc, 10'd0);
    check("rst_done", b10.done, 1'b0);
    check("rst_addr", b10.imem_addr, 10'd0);

    // ---- IDLE ignores branch
    reset = 1'b0;
    b10.branch_taken = 1'b1; b10.branch_target = 10'd9;
    step();
    check("idle_addr", b10.imem_addr, 10'd0);
    check("idle_valid", b10.instr_valid, 1'b0);
    b10.branch_taken = 1'b0;

    // ---- 1: straight-line fetch
    clear_rom();
    rom[0] = 9'h012; rom[1] = 9'h0A5; rom[2] = 9'h033;
    reset_and_start();
    check("t1_start_valid", b10.instr_valid, 1'b0);
    check("t1_start_addr", b10.imem_addr, 10'd0);
    b10.start = 1'b0;
    step();
    check("t1_mach0", b10.mach_code, 9'h012);
    check("t1_ipc0", b10.instr_pc, 10'd0);
    check("t1_valid0", b10.instr_valid, 1'b1);
    check("t1_mode0", b10.mode, 1'b0);
    b10.start = 1'b1;                 // start in RUN is ignored
    step();
    b10.start = 1'b0;
    check("t1_mach1", b10.mach_code, 9'h0A5);
    check("t1_ipc1", b10.instr_pc, 10'd1);
    step();
    check("t1_mach2", b10.mach_code, 9'h033);
    check("t1_ipc2", b10.instr_pc, 10'd2);
    check("t1_valid2", b10.instr_valid, 1'b1);

    // ---- 2: mode switch
    clear_rom();
    rom[0] = 9'h011; rom[1] = 9'h1FF; rom[2] = 9'h04B; rom[3] = 9'h1FF; rom[4] = 9'h022;
    reset_and_start();
    step();
    check("t2_mach0", b10.mach_code, 9'h011);
    check("t2_mode0", b10.mode, 1'b0);
    step();
    check("t2_bubble_valid", b10.instr_valid, 1'b0);
    check("t2_bubble_mach", b10.mach_code, 9'h000);
    step();
    check("t2_mach2", b10.mach_code, 9'h04B);
    check("t2_mode2", b10.mode, 1'b1);
    check("t2_valid2", b10.instr_valid, 1'b1);
    step();
    check("t2_bubble2_valid", b10.instr_valid, 1'b0);
    step();
    check("t2_mach4", b10.mach_code, 9'h022);
    check("t2_mode4", b10.mode, 1'b0);
    check("t2_ipc4", b10.instr_pc, 10'd4);

    // ---- 3: branch at pc=5, without and with stall
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 9'h040 + 9'(i);
    for (int pass = 0; pass < 2; pass++) begin
      reset_and_start();
      for (int k = 0; k < 5; k++) step();
      check("t3_pre_addr", b10.imem_addr, 10'd5);
      check("t3_pre_mach", b10.mach_code, 9'h044);
      b10.branch_taken = 1'b1; b10.branch_target = 10'd10;
      b10.stall = (pass == 1);
      step();
      b10.branch_taken = 1'b0; b10.stall = 1'b0;
      check("t3_drop_valid", b10.instr_valid, 1'b0);
      check("t3_drop_mach", b10.mach_code, 9'h000);
      check("t3_redir_addr", b10.imem_addr, 10'd10);
      step();
      check("t3_tgt_ipc", b10.instr_pc, 10'd10);
      check("t3_tgt_mach", b10.mach_code, 9'h04A);
      check("t3_tgt_valid", b10.instr_valid, 1'b1);
    end

    // ---- 4: stall holds three cycles
    clear_rom();
    rom[0] = 9'h010; rom[1] = 9'h020; rom[2] = 9'h0C7; rom[3] = 9'h0D8; rom[4] = 9'h0E9;
    reset_and_start();
    step(); step(); step();
    check("t4_mach", b10.mach_code, 9'h0C7);
    b10.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_hold_mach", b10.mach_code, 9'h0C7);
      check("t4_hold_ipc", b10.instr_pc, 10'd2);
      check("t4_hold_addr", b10.imem_addr, 10'd3);
      check("t4_hold_valid", b10.instr_valid, 1'b1);
    end
    b10.stall = 1'b0;
    step();
    check("t4_resume_mach", b10.mach_code, 9'h0D8);
    check("t4_resume_ipc", b10.instr_pc, 10'd3);
    step();
    check("t4_next_mach", b10.mach_code, 9'h0E9);

    // ---- 5: halt
    clear_rom();
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h1FE; rom[4] = 9'h005;
    reset_and_start();
    step(); step(); step();
    check("t5_pre_done", b10.done, 1'b0);
    check("t5_pre_addr", b10.imem_addr, 10'd3);
    step();
    check("t5_done", b10.done, 1'b1);
    check("t5_valid", b10.instr_valid, 1'b0);
    check("t5_addr", b10.imem_addr, 10'd3);
    b10.start = 1'b1;
    step();
    b10.start = 1'b0;
    b10.branch_taken = 1'b1; b10.branch_target = 10'd7;
    step();
    b10.branch_taken = 1'b0;
    check("t5_frozen_addr", b10.imem_addr, 10'd3);
    check("t5_frozen_done", b10.done, 1'b1);
    check("t5_frozen_valid", b10.instr_valid, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_rst_done", b10.done, 1'b0);
    check("t5_rst_addr", b10.imem_addr, 10'd0);
    step();
    check("t5_idle_addr", b10.imem_addr, 10'd0);
    check("t5_idle_valid", b10.instr_valid, 1'b0);

    // ---- 6: PC_W = 4 wraparound and mid-run reset
    step();
    reset4 = 1'b0;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    for (int k = 0; k < 15; k++) step();
    check("t6_ipc14", b4.instr_pc, 4'd14);
    check("t6_mach14", b4.mach_code, 9'h10E);
    step();
    check("t6_ipc15", b4.instr_pc, 4'd15);
    check("t6_addr_wrap", b4.imem_addr, 4'd0);
    step();
    check("t6_ipc0", b4.instr_pc, 4'd0);
    check("t6_mach0", b4.mach_code, 9'h100);
    step();
    check("t6_ipc1", b4.instr_pc, 4'd1);
    check("t6_valid1", b4.instr_valid, 1'b1);
    reset4 = 1'b1;
    step();
    check("t6_rst_mach", b4.mach_code, 9'h000);
    check("t6_rst_valid", b4.instr_valid, 1'b0);
    check("t6_rst_ipc", b4.instr_pc, 4'd0);
    check("t6_rst_addr", b4.imem_addr, 4'd0);
    check("t6_rst_mode", b4.mode, 1'b0);
    check("t6_rst_done", b4.done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
